// File: rtl/hex_display_ctrl_if.sv
// Bus between the debug-display source and hex_display_ctrl.
//   master : drives value_i, load_i, blank_lz_i, en_i; observes the display outputs
//   slave  : the controller; consumes the control inputs, drives hex_o/seg_o/an_o/frame_o
interface hex_display_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] value_i;
  logic                load_i;
  logic                blank_lz_i;
  logic                en_i;
  logic [7*DIGITS-1:0] hex_o;
  logic [6:0]          seg_o;
  logic [DIGITS-1:0]   an_o;
  logic                frame_o;

  modport master (
    output value_i, load_i, blank_lz_i, en_i,
    input  hex_o, seg_o, an_o, frame_o
  );

  modport slave (
    input  value_i, load_i, blank_lz_i, en_i,
    output hex_o, seg_o, an_o, frame_o
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment controller for the processor debug display.
// Shows DIGITS hex digits on static per-digit outputs (hex_o) and on a time-multiplexed
// scan (seg_o/an_o). New values are staged in a shadow register and only committed to the
// displayed value at the end of a scan frame, so the display never tears.
// Ports:
//   clk_i  - system clock, rising edge
//   reset  - asynchronous active-high reset
//   bus    - slave modport: value_i, load_i, blank_lz_i, en_i in;
//            hex_o (gfedcba per digit), seg_o, an_o (one-hot), frame_o out
module hex_display_ctrl #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input logic               clk_i,
  input logic               reset,
  hex_display_ctrl_if.slave bus
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
  localparam logic            OffLvl  = ACTIVE_LOW;

  logic [4*DIGITS-1:0] r_shadow;
  logic                r_pending;
  logic [4*DIGITS-1:0] r_disp;
  logic [DivW-1:0]     r_div_cnt;
  logic [IdxW-1:0]     r_dig_idx;
  logic [7*DIGITS-1:0] r_hex;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame;

  logic                w_div_last;
  logic                w_wrap;
  logic                w_lead;
  logic [DIGITS-1:0]   w_blank;
  logic [6:0]          w_pat;
  logic [7*DIGITS-1:0] w_hex;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_an;

  // Active-high segment patterns, bit 0 = segment a.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  assign w_div_last = (r_div_cnt == DivLast);
  assign w_wrap     = w_div_last && (r_dig_idx == IdxLast);

  // Leading-zero mask: walk down from the top digit while every digit seen so far is zero.
  // Digit 0 is excluded so a zero value still shows a single 0.
  always_comb begin
    w_lead  = bus.blank_lz_i;
    w_blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (w_lead && (r_disp[4*k +: 4] == 4'h0)) begin
        w_blank[k] = 1'b1;
      end else begin
        w_lead = 1'b0;
      end
    end
  end

  // Built active-high, then inverted as a whole for active-low boards.
  always_comb begin
    w_hex = '0;
    w_seg = '0;
    w_an  = '0;
    w_pat = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_pat = (w_blank[k] || !bus.en_i) ? 7'h00 : f_decode(r_disp[4*k +: 4]);
      w_hex[7*k +: 7] = w_pat;
      if (r_dig_idx == IdxW'(k)) begin
        w_seg   = w_pat;
        w_an[k] = bus.en_i;
      end
    end
    if (ACTIVE_LOW) begin
      w_hex = ~w_hex;
      w_seg = ~w_seg;
      w_an  = ~w_an;
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_disp    <= '0;
      r_div_cnt <= '0;
      r_dig_idx <= '0;
      r_hex     <= {(7*DIGITS){OffLvl}};
      r_seg     <= {7{OffLvl}};
      r_an      <= {DIGITS{OffLvl}};
      r_frame   <= 1'b0;
    end else begin
      r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
      if (w_div_last) begin
        r_dig_idx <= (r_dig_idx == IdxLast) ? '0 : r_dig_idx + 1'b1;
      end

      if (bus.load_i) begin
        r_shadow <= bus.value_i;
      end

      // A load coinciding with the wrap bypasses the shadow so it is not delayed a frame.
      if (w_wrap) begin
        r_pending <= 1'b0;
        if (bus.load_i) begin
          r_disp <= bus.value_i;
        end else if (r_pending) begin
          r_disp <= r_shadow;
        end
      end else if (bus.load_i) begin
        r_pending <= 1'b1;
      end

      r_hex   <= w_hex;
      r_seg   <= w_seg;
      r_an    <= w_an;
      r_frame <= w_wrap;
    end
  end

  assign bus.hex_o   = r_hex;
  assign bus.seg_o   = r_seg;
  assign bus.an_o    = r_an;
  assign bus.frame_o = r_frame;

endmodule
